// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the banked data memory.
// Holds the controller state encoding, the legal read-latency values,
// the byte-lane count helper and the per-byte even-parity function.
`timescale 1ns/1ps
package dmem_pkg;

    // Controller state: INIT sweeps the array, READY serves requests.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Legal read latencies.
    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    // Number of byte lanes in a word of the given width.
    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    // Even-parity bit for one byte: byte plus this bit carries an even number of ones.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_banked_if.sv
// dmem_banked_if: load/store bus between the CPU and dmem_banked.
//
// Handshake: a request is accepted on a rising edge where req_i and ready_o
// are both high; we_i, be_i, addr_i and wdata_i are sampled on that same edge.
// ready_o low means the master must hold off (stall). Reads answer with a
// single-cycle rvalid_o pulse a fixed latency later; there is no backpressure
// on the response side. err_o/perr_o are meaningful only in a response cycle.
`timescale 1ns/1ps
interface dmem_banked_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic                  req_i;
    logic                  we_i;
    logic [DATA_W/8-1:0]   be_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic                  ready_o;
    logic                  rvalid_o;
    logic [DATA_W-1:0]     rdata_o;
    logic                  err_o;
    logic                  perr_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  ready_o, rvalid_o, rdata_o, err_o, perr_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output ready_o, rvalid_o, rdata_o, err_o, perr_o
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with per-byte-lane write enables and a
// combinational read port. With DMEM_PARITY_EN defined it also keeps one
// parity bit per lane alongside the data.
`timescale 1ns/1ps
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_PARITY_EN
    input  logic [LANES-1:0]  wpar,
    output logic [LANES-1:0]  rpar,
`endif
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Lane-granular data write; lanes with we=0 keep their contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we[k]) begin
                mem[waddr][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];

    // Parity bits follow the same lane enables as the data they protect.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we[k]) begin
                par_mem[waddr][k] <= wpar[k];
            end
        end
    end

    assign rpar = par_mem[raddr];
`endif

endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: parametrised data memory for the CPU load/store unit.
// Owns the INIT/READY controller (power-up clear sweep), the address range
// check and the 1- or 2-stage registered read pipeline around dmem_array.
// Optional per-lane parity storage and checking is enabled by the macro
// DMEM_PARITY_EN; without it perr_o is tied low.
`timescale 1ns/1ps
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 8,
    parameter int                DEPTH        = 256,
    parameter int                RD_LAT       = 1,
    parameter int                CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
    input  logic          CLK,
    input  logic          RST,
    dmem_banked_if.slave  bus,
    output state_e        state_o
);

    localparam int LANES = lane_count(DATA_W);
    localparam int CLR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CLR_W-1:0] LAST_ADDR = CLR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [CLR_W-1:0]    clr_addr_q, clr_addr_d;

    logic                ready;
    logic                accept;
    logic                oor;

    logic [LANES-1:0]    arr_we;
    logic [CLR_W-1:0]    arr_waddr;
    logic [DATA_W-1:0]   arr_wdata;
    logic [DATA_W-1:0]   arr_rdata;
    logic                par_bad;

    // Stage-1 response, computed in the acceptance cycle.
    logic                s1_rv_d, s1_err_d, s1_perr_d;
    logic [DATA_W-1:0]   s1_data_d;

    // Response entering the output registers.
    logic                last_rv, last_err, last_perr;
    logic [DATA_W-1:0]   last_data;

    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Requests are only taken in READY and never in a reset cycle.
    assign ready  = (state_q == READY) && !RST;
    assign accept = bus.req_i && ready;
    assign oor    = (32'(bus.addr_i) >= 32'(DEPTH));

    // Controller: clear sweep in INIT, request writes in READY.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        arr_we     = '0;
        arr_waddr  = bus.addr_i[CLR_W-1:0];
        arr_wdata  = bus.wdata_i;
        case (state_q)
            INIT: begin
                arr_we    = '1;
                arr_waddr = clr_addr_q;
                arr_wdata = INIT_VAL;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + CLR_W'(1);
                end
            end
            READY: begin
                if (accept && bus.we_i && !oor) begin
                    arr_we = bus.be_i;
                end
            end
        endcase
    end

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] arr_wpar, arr_rpar;

    // Parity generated from whatever is being written; every read lane checked.
    always_comb begin
        par_bad = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            arr_wpar[k] = even_parity(arr_wdata[k*8 +: 8]);
            if (even_parity(arr_rdata[k*8 +: 8]) != arr_rpar[k]) begin
                par_bad = 1'b1;
            end
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (CLR_W),
        .LANES  (LANES)
    ) u_array (
        .clk    (CLK),
        .we     (arr_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
`ifdef DMEM_PARITY_EN
        .wpar   (arr_wpar),
        .rpar   (arr_rpar),
`endif
        .raddr  (bus.addr_i[CLR_W-1:0]),
        .rdata  (arr_rdata)
    );

    // Response for the request accepted this cycle; out-of-range wins over parity.
    always_comb begin
        s1_rv_d   = accept && !bus.we_i;
        s1_err_d  = accept && oor;
        s1_data_d = oor ? '0 : arr_rdata;
        s1_perr_d = accept && !bus.we_i && !oor && par_bad;
    end

    generate
        if (RD_LAT == RD_LAT_2) begin : g_lat2
            logic              s1_rv_q, s1_err_q, s1_perr_q;
            logic [DATA_W-1:0] s1_data_q;

            // Extra pipeline stage; flushed by reset so in-flight reads vanish.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    s1_rv_q   <= 1'b0;
                    s1_err_q  <= 1'b0;
                    s1_perr_q <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_rv_q   <= s1_rv_d;
                    s1_err_q  <= s1_err_d;
                    s1_perr_q <= s1_perr_d;
                    s1_data_q <= s1_data_d;
                end
            end

            assign last_rv   = s1_rv_q;
            assign last_err  = s1_err_q;
            assign last_perr = s1_perr_q;
            assign last_data = s1_data_q;
        end else begin : g_lat1
            assign last_rv   = s1_rv_d;
            assign last_err  = s1_err_d;
            assign last_perr = s1_perr_d;
            assign last_data = s1_data_d;
        end
    endgenerate

    // Output stage: flags pulse for one cycle, read data holds between reads.
    always_comb begin
        rvalid_d = last_rv;
        err_d    = last_err;
        perr_d   = last_perr;
        rdata_d  = last_rv ? last_data : rdata_q;
    end

    // State, sweep pointer and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= (CLEAR_ON_RST != 0) ? INIT : READY;
            clr_addr_q <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            perr_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            perr_q     <= perr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.ready_o  = ready;
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = err_q;
    assign bus.perr_o   = perr_q;
    assign bus.rdata_o  = rdata_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: two instances share one stimulus stream.
//   dut_a: DATA_W=32, DEPTH=16,  RD_LAT=1
//   dut_b: DATA_W=32, DEPTH=200, RD_LAT=2
// Each issued request pushes the expected response (with its due cycle)
// into a per-instance queue; monitors pop and compare on every response.
// Build with DMEM_PARITY_EN to exercise the parity-flip read.
`timescale 1ns/1ps
module tb_dmem_banked;
    import dmem_pkg::*;

    typedef struct packed {
        logic [15:0] cyc;
        logic        rv;
        logic        err;
        logic        perr;
        logic [31:0] data;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    exp_t   exp_qa[$];
    exp_t   exp_qb[$];
    exp_t   ea, eb;
    logic [31:0] model [2][256];
    logic   flip_a = 1'b0;
    state_e st_a, st_b;
    int     la, lb;

    dmem_banked_if #(.DATA_W(32), .ADDR_W(8)) bus_a ();
    dmem_banked_if #(.DATA_W(32), .ADDR_W(8)) bus_b ();

    dmem_banked #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(16), .RD_LAT(1),
        .CLEAR_ON_RST(1), .INIT_VAL(32'h0)
    ) dut_a (
        .CLK(clk), .RST(rst), .bus(bus_a), .state_o(st_a)
    );

    dmem_banked #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(2),
        .CLEAR_ON_RST(1), .INIT_VAL(32'h0)
    ) dut_b (
        .CLK(clk), .RST(rst), .bus(bus_b), .state_o(st_b)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [7:0] addr, input logic [31:0] data);
        bus_a.req_i = req; bus_a.we_i = we; bus_a.be_i = be; bus_a.addr_i = addr; bus_a.wdata_i = data;
        bus_b.req_i = req; bus_b.we_i = we; bus_b.be_i = be; bus_b.addr_i = addr; bus_b.wdata_i = data;
    endtask

    task automatic push_exp(input int inst, input logic we, input logic [3:0] be,
                            input logic [7:0] addr, input logic [31:0] data);
        int depth;
        int lat;
        exp_t e;
        logic [31:0] cur;
        depth = (inst == 0) ? 16 : 200;
        lat   = (inst == 0) ? 1 : 2;
        e     = '0;
        e.cyc = 16'(cyc + lat);
        if (int'(addr) >= depth) begin
            e.err = 1'b1;
            e.rv  = !we;
            if (inst == 0) exp_qa.push_back(e); else exp_qb.push_back(e);
        end else if (we) begin
            cur = model[inst][addr];
            for (int k = 0; k < 4; k++) begin
                if (be[k]) cur[k*8 +: 8] = data[k*8 +: 8];
            end
            model[inst][addr] = cur;
            if (inst == 0 && addr == 8'd7 && be[0]) flip_a = 1'b0;
        end else begin
            e.rv   = 1'b1;
            e.data = model[inst][addr];
            e.perr = (inst == 0) && (addr == 8'd7) && flip_a;
            if (inst == 0) exp_qa.push_back(e); else exp_qb.push_back(e);
        end
    endtask

    // One accepted request per call; returns #1 after its acceptance edge.
    task automatic issue(input logic we, input logic [3:0] be, input logic [7:0] addr,
                         input logic [31:0] data);
        drive(1'b1, we, be, addr, data);
        push_exp(0, we, be, addr, data);
        push_exp(1, we, be, addr, data);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'h0, 8'h0, 32'h0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!(bus_a.ready_o === 1'b1 && bus_b.ready_o === 1'b1) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_ready_timeout", 32'(n < 400), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic count_low(input int ncyc, output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus_a.ready_o !== 1'b1) na++;
            if (bus_b.ready_o !== 1'b1) nb++;
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            model[0][i] = 32'h0;
            model[1][i] = 32'h0;
        end
        flip_a = 1'b0;
    endtask

    // scoreboard monitor, instance a
    always @(negedge clk) begin
        if (bus_a.rvalid_o === 1'b1 || bus_a.err_o === 1'b1 || bus_a.perr_o === 1'b1) begin
            if (exp_qa.size() == 0) begin
                chk("a_unexpected_resp", 32'd1, 32'd0);
            end else begin
                ea = exp_qa.pop_front();
                chk("a_resp_cycle", cyc & 32'hFFFF, {16'h0, ea.cyc});
                chk("a_rvalid", 32'(bus_a.rvalid_o), 32'(ea.rv));
                chk("a_err", 32'(bus_a.err_o), 32'(ea.err));
                chk("a_perr", 32'(bus_a.perr_o), 32'(ea.perr));
                if (ea.rv) chk("a_rdata", bus_a.rdata_o, ea.data);
            end
        end
    end

    // scoreboard monitor, instance b
    always @(negedge clk) begin
        if (bus_b.rvalid_o === 1'b1 || bus_b.err_o === 1'b1 || bus_b.perr_o === 1'b1) begin
            if (exp_qb.size() == 0) begin
                chk("b_unexpected_resp", 32'd1, 32'd0);
            end else begin
                eb = exp_qb.pop_front();
                chk("b_resp_cycle", cyc & 32'hFFFF, {16'h0, eb.cyc});
                chk("b_rvalid", 32'(bus_b.rvalid_o), 32'(eb.rv));
                chk("b_err", 32'(bus_b.err_o), 32'(eb.err));
                chk("b_perr", 32'(bus_b.perr_o), 32'(eb.perr));
                if (eb.rv) chk("b_rdata", bus_b.rdata_o, eb.data);
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // main stimulus
    initial begin
        drive(1'b0, 1'b0, 4'h0, 8'h0, 32'h0);
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", 32'(bus_a.ready_o), 32'd0);
        chk("rst_ready_b", 32'(bus_b.ready_o), 32'd0);
        chk("rst_rvalid_a", 32'(bus_a.rvalid_o), 32'd0);
        chk("rst_rvalid_b", 32'(bus_b.rvalid_o), 32'd0);
        chk("rst_err_a", 32'(bus_a.err_o), 32'd0);
        chk("rst_perr_b", 32'(bus_b.perr_o), 32'd0);
        chk("rst_rdata_a", bus_a.rdata_o, 32'h0);
        chk("rst_rdata_b", bus_b.rdata_o, 32'h0);
        chk("rst_state_a", 32'(st_a), 32'(INIT));
        chk("rst_state_b", 32'(st_b), 32'(INIT));
        rst = 1'b0;

        // clear sweep takes exactly DEPTH cycles
        count_low(260, la, lb);
        chk("sweep_len_a", 32'(la), 32'd16);
        chk("sweep_len_b", 32'(lb), 32'd200);
        chk("ready_state_a", 32'(st_a), 32'(READY));
        wait_ready();

        // swept contents read back as zero
        for (int i = 0; i < 16; i++) issue(1'b0, 4'h0, 8'(i), 32'h0);

        // byte-lane merge: 0xAABBCCDD then 0x11223344 with lanes 0 and 2 -> 0xAA22CC44
        issue(1'b1, 4'hF, 8'd5, 32'hAABBCCDD);
        issue(1'b1, 4'b0101, 8'd5, 32'h11223344);
        issue(1'b0, 4'h0, 8'd5, 32'h0);

        // back-to-back reads 53, 17, 42
        issue(1'b1, 4'hF, 8'd1, 32'd53);
        issue(1'b1, 4'hF, 8'd2, 32'd17);
        issue(1'b1, 4'hF, 8'd3, 32'd42);
        issue(1'b0, 4'h0, 8'd1, 32'h0);
        issue(1'b0, 4'h0, 8'd2, 32'h0);
        issue(1'b0, 4'h0, 8'd3, 32'h0);

        // read directly after write, then an all-lanes-off write
        issue(1'b1, 4'hF, 8'd9, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 8'd9, 32'h0);
        issue(1'b1, 4'h0, 8'd9, 32'hFFFFFFFF);
        issue(1'b0, 4'h0, 8'd9, 32'h0);

        // range boundaries: 15/16 for a, 199/200 for b, 250 for both
        issue(1'b1, 4'hF, 8'd15, 32'h0F0F0F0F);
        issue(1'b1, 4'hF, 8'd16, 32'h16161616);
        issue(1'b1, 4'hF, 8'd199, 32'hC7C7C7C7);
        issue(1'b1, 4'hF, 8'd200, 32'hC8C8C8C8);
        issue(1'b1, 4'hF, 8'd250, 32'hFAFAFAFA);
        issue(1'b1, 4'hF, 8'd100, 32'h12345678);
        issue(1'b0, 4'h0, 8'd15, 32'h0);
        issue(1'b0, 4'h0, 8'd16, 32'h0);
        issue(1'b0, 4'h0, 8'd199, 32'h0);
        issue(1'b0, 4'h0, 8'd200, 32'h0);
        issue(1'b0, 4'h0, 8'd250, 32'h0);
        issue(1'b0, 4'h0, 8'd100, 32'h0);
        issue(1'b0, 4'h0, 8'd0, 32'h0);
        issue(1'b0, 4'h0, 8'd10, 32'h0);
        drain();

        // parity: flip one stored bit of word 7 in dut_a
        issue(1'b1, 4'hF, 8'd7, 32'h000000A5);
`ifdef DMEM_PARITY_EN
        dut_a.u_array.mem[7][0] = ~dut_a.u_array.mem[7][0];
        model[0][7][0] = ~model[0][7][0];
        flip_a = 1'b1;
        issue(1'b0, 4'h0, 8'd7, 32'h0);
        issue(1'b1, 4'hF, 8'd7, 32'h0000005A);
`endif
        issue(1'b0, 4'h0, 8'd7, 32'h0);
        drain();

        // reset one cycle after a read: a (latency 1) answers, b drops it
        issue(1'b1, 4'hF, 8'd0, 32'h0BADF00D);
        issue(1'b0, 4'h0, 8'd0, 32'h0);
        void'(exp_qb.pop_back());
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_state_a", 32'(st_a), 32'(INIT));
        chk("midrst_state_b", 32'(st_b), 32'(INIT));
        rst = 1'b0;

        // requests during INIT are ignored (no response, no write)
        drive(1'b1, 1'b0, 4'h0, 8'd3, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        drive(1'b1, 1'b1, 4'hF, 8'd3, 32'hFFFFFFFF);
        repeat (4) begin @(posedge clk); #1; end
        drive(1'b0, 1'b0, 4'h0, 8'h0, 32'h0);
        repeat (40) begin @(posedge clk); #1; end

        // reset again mid-sweep: both sweeps restart from address 0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_low(260, la, lb);
        chk("resweep_len_a", 32'(la), 32'd16);
        chk("resweep_len_b", 32'(lb), 32'd200);
        clear_model();
        wait_ready();
        issue(1'b0, 4'h0, 8'd0, 32'h0);
        issue(1'b0, 4'h0, 8'd3, 32'h0);
        issue(1'b0, 4'h0, 8'd5, 32'h0);
        issue(1'b0, 4'h0, 8'd100, 32'h0);
        drain();

        chk("queue_a_empty", 32'(exp_qa.size()), 32'd0);
        chk("queue_b_empty", 32'(exp_qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
